// File: rtl/puzzle_move_engine.sv
// 3x3 sliding-puzzle board engine: loads a preset board while the game is
// in board selection, applies single direction-button moves during play,
// and reports a one-cycle move pulse plus a level "solved" flag.
module puzzle_move_engine (
  input  logic        clk_d,
  input  logic        rst,
  input  logic [1:0]  game_status,
  input  logic [1:0]  board_sel,
  input  logic        btn_up,
  input  logic        btn_down,
  input  logic        btn_left,
  input  logic        btn_right,
  output logic        active,
  output logic        win_flag,
  output logic [35:0] board_flat,
  output logic [3:0]  blank_pos
);

  // Game states as driven by the game-status FSM.
  localparam logic [1:0] ST_CHOSE_BOARD  = 2'b00;
  localparam logic [1:0] ST_GAMING       = 2'b01;
  localparam logic [1:0] ST_GAME_INITIAL = 2'b10;
  localparam logic [1:0] ST_WINNED       = 2'b11;

  // Boards packed with cell k in bits [4k+3:4k] (cell 8 is the top nibble).
  localparam logic [35:0] SOLVED_FLAT = 36'h087654321;
  localparam logic [35:0] P0_FLAT     = 36'h807654321;
  localparam logic [35:0] P1_FLAT     = 36'h857604321;
  localparam logic [35:0] P2_FLAT     = 36'h857640321;
  localparam logic [35:0] P3_FLAT     = 36'h687524310;
  localparam logic [3:0]  P0_BLANK    = 4'd7;

  logic [1:0]  status_q, status_d;
  logic [3:0]  hist_q, hist_d;
  logic [3:0]  board_q [9];
  logic [3:0]  board_d [9];
  logic [3:0]  blank_q, blank_d;
  logic        active_q, active_d;
  logic        win_q, win_d;

  logic [3:0]  btn_vec;
  logic [3:0]  press;
  logic [35:0] rom_flat;
  logic [3:0]  rom_blank;
  logic [3:0]  rom_cell [9];
  logic [35:0] next_flat;
  logic [1:0]  blank_col;
  logic [3:0]  target;
  logic        legal;

  // Button vector order: bit0 up, bit1 down, bit2 left, bit3 right.
  assign btn_vec = {btn_right, btn_left, btn_down, btn_up};
  assign press   = btn_vec & ~hist_q;
  assign hist_d  = btn_vec;
  assign status_d = game_status;

  // Preset board ROM lookup.
  always_comb begin
    rom_flat  = P0_FLAT;
    rom_blank = P0_BLANK;
    case (board_sel)
      2'd0: begin rom_flat = P0_FLAT; rom_blank = 4'd7; end
      2'd1: begin rom_flat = P1_FLAT; rom_blank = 4'd4; end
      2'd2: begin rom_flat = P2_FLAT; rom_blank = 4'd3; end
      default: begin rom_flat = P3_FLAT; rom_blank = 4'd0; end
    endcase
  end

  // Cell unpacking/packing between flat vectors and per-cell arrays.
  genvar gi;
  generate
    for (gi = 0; gi < 9; gi++) begin : g_cells
      assign rom_cell[gi]            = rom_flat[4*gi +: 4];
      assign board_flat[4*gi +: 4]   = board_q[gi];
      assign next_flat[4*gi +: 4]    = board_d[gi];
    end
  endgenerate

  // Column of the blank cell, used by the left/right legality checks.
  always_comb begin
    case (blank_q)
      4'd0, 4'd3, 4'd6: blank_col = 2'd0;
      4'd1, 4'd4, 4'd7: blank_col = 2'd1;
      4'd2, 4'd5, 4'd8: blank_col = 2'd2;
      default:          blank_col = 2'd0;
    endcase
  end

  // Target cell and legality; zero or multiple presses fall to no-move.
  always_comb begin
    target = blank_q;
    legal  = 1'b0;
    case (press)
      4'b0001: begin legal = (blank_q >= 4'd3);    target = blank_q - 4'd3; end
      4'b0010: begin legal = (blank_q <= 4'd5);    target = blank_q + 4'd3; end
      4'b0100: begin legal = (blank_col != 2'd0);  target = blank_q - 4'd1; end
      4'b1000: begin legal = (blank_col != 2'd2);  target = blank_q + 4'd1; end
      default: begin legal = 1'b0;                 target = blank_q;        end
    endcase
  end

  // Next board, blank and move pulse; state decisions use the registered status.
  always_comb begin
    board_d  = board_q;
    blank_d  = blank_q;
    active_d = 1'b0;
    case (status_q)
      ST_CHOSE_BOARD: begin
        board_d = rom_cell;
        blank_d = rom_blank;
      end
      ST_GAMING, ST_GAME_INITIAL: begin
        if (legal) begin
          board_d[blank_q] = board_q[target];
          board_d[target]  = board_q[blank_q];
          blank_d          = target;
          active_d         = 1'b1;
        end
      end
      default: ; // WINNED: board frozen, presses discarded
    endcase
  end

  // Win flag follows the board being written at the same edge.
  always_comb begin
    case (status_q)
      ST_CHOSE_BOARD: win_d = 1'b0;
      ST_WINNED:      win_d = 1'b1;
      default:        win_d = (next_flat == SOLVED_FLAT);
    endcase
  end

  // State registers; reset restores P0 and arms the button history high.
  always_ff @(posedge clk_d) begin
    if (!rst) begin
      status_q <= ST_CHOSE_BOARD;
      hist_q   <= 4'b1111;
      for (int i = 0; i < 9; i++) board_q[i] <= P0_FLAT[4*i +: 4];
      blank_q  <= P0_BLANK;
      active_q <= 1'b0;
      win_q    <= 1'b0;
    end else begin
      status_q <= status_d;
      hist_q   <= hist_d;
      board_q  <= board_d;
      blank_q  <= blank_d;
      active_q <= active_d;
      win_q    <= win_d;
    end
  end

  assign active    = active_q;
  assign win_flag  = win_q;
  assign blank_pos = blank_q;

endmodule

// File: tb/tb_puzzle_move_engine.sv
// Self-checking bench for puzzle_move_engine: directed scenarios followed by
// randomized play, all compared against a cell-array reference model.
module tb_puzzle_move_engine;

  logic        clk_d = 1'b0;
  logic        rst = 1'b0;
  logic [1:0]  game_status = 2'b00;
  logic [1:0]  board_sel = 2'b00;
  logic        btn_up = 1'b0, btn_down = 1'b0, btn_left = 1'b0, btn_right = 1'b0;
  logic        active, win_flag;
  logic [35:0] board_flat;
  logic [3:0]  blank_pos;

  puzzle_move_engine dut (
    .clk_d(clk_d), .rst(rst), .game_status(game_status), .board_sel(board_sel),
    .btn_up(btn_up), .btn_down(btn_down), .btn_left(btn_left), .btn_right(btn_right),
    .active(active), .win_flag(win_flag), .board_flat(board_flat), .blank_pos(blank_pos)
  );

  always #5 clk_d = ~clk_d;

  int checks = 0;
  int failures = 0;
  int cyc = 0;

  task automatic check_eq(input string tag, input logic [35:0] got, input logic [35:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s cycle=%0d got=%h expected=%h", tag, cyc, got, exp);
    end
  endtask

  // Reference model: plain cell array, row/column arithmetic for moves.
  int rom [4][9] = '{'{1,2,3,4,5,6,7,0,8}, '{1,2,3,4,0,6,7,5,8},
                     '{1,2,3,0,4,6,7,5,8}, '{0,1,3,4,2,5,7,8,6}};
  int rom_blank [4] = '{7, 4, 3, 0};
  int m_board [9];
  int m_blank;
  logic [3:0] m_hist;
  logic [1:0] m_stat;
  logic m_active, m_win;

  function automatic logic [35:0] m_flat();
    logic [35:0] f;
    for (int i = 0; i < 9; i++) f[4*i +: 4] = 4'(m_board[i]);
    return f;
  endfunction

  function automatic bit m_solved();
    for (int i = 0; i < 8; i++) if (m_board[i] != i + 1) return 0;
    return m_board[8] == 0;
  endfunction

  task automatic model_edge();
    logic [3:0] btn, press;
    int r, c, tr, tc, t;
    if (!rst) begin
      m_board = rom[0]; m_blank = 7; m_hist = 4'b1111;
      m_stat = 2'b00; m_active = 0; m_win = 0;
      return;
    end
    btn = {btn_right, btn_left, btn_down, btn_up};
    press = btn & ~m_hist;
    m_active = 0;
    if (m_stat == 2'b00) begin
      m_board = rom[board_sel]; m_blank = rom_blank[board_sel]; m_win = 0;
    end else if (m_stat == 2'b11) begin
      m_win = 1;
    end else begin
      if ($countones(press) == 1) begin
        r = m_blank / 3; c = m_blank % 3; tr = r; tc = c;
        if (press[0]) tr = r - 1;
        if (press[1]) tr = r + 1;
        if (press[2]) tc = c - 1;
        if (press[3]) tc = c + 1;
        if (tr >= 0 && tr <= 2 && tc >= 0 && tc <= 2) begin
          t = tr * 3 + tc;
          m_board[m_blank] = m_board[t];
          m_board[t] = 0;
          m_blank = t;
          m_active = 1;
        end
      end
      m_win = m_solved();
    end
    m_hist = btn;
    m_stat = game_status;
  endtask

  // One clock: model follows the edge, outputs compared on the falling edge.
  task automatic step();
    @(posedge clk_d);
    model_edge();
    @(negedge clk_d);
    cyc++;
    check_eq("board", board_flat, m_flat());
    check_eq("blank", {32'd0, blank_pos}, 36'(m_blank));
    check_eq("active", {35'd0, active}, {35'd0, m_active});
    check_eq("win", {35'd0, win_flag}, {35'd0, m_win});
  endtask

  task automatic steps(input int n);
    for (int i = 0; i < n; i++) step();
  endtask

  task automatic set_btn(input logic [3:0] b);
    {btn_right, btn_left, btn_down, btn_up} = b;
  endtask

  task automatic load(input logic [1:0] sel, input logic [1:0] play);
    set_btn(4'b0000);
    game_status = 2'b00; board_sel = sel;
    steps(2);
    game_status = play;
    steps(2);
  endtask

  // Press one button pattern for a cycle, then release for a cycle.
  task automatic tap(input logic [3:0] b);
    set_btn(b); step();
    set_btn(4'b0000); step();
  endtask

  int pulses;
  int rv;

  initial begin
    // 1: reset then select P3
    rst = 1'b0; board_sel = 2'd3; steps(2);
    rst = 1'b1; steps(2);
    check_eq("t1_p3", board_flat, 36'h687524310);
    check_eq("t1_blank", {32'd0, blank_pos}, 36'd0);

    // 2: P0, GAME_INITIAL, one right press solves it
    load(2'd0, 2'b10);
    set_btn(4'b1000); step();
    check_eq("t2_active", {35'd0, active}, 36'd1);
    check_eq("t2_solved", board_flat, 36'h087654321);
    check_eq("t2_win", {35'd0, win_flag}, 36'd1);
    set_btn(4'b0000); step();
    check_eq("t2_pulse_end", {35'd0, active}, 36'd0);

    // 3: P1, down then right
    load(2'd1, 2'b01);
    tap(4'b0010);
    check_eq("t3_blank7", {32'd0, blank_pos}, 36'd7);
    check_eq("t3_nowin", {35'd0, win_flag}, 36'd0);
    tap(4'b1000);
    check_eq("t3_win", {35'd0, win_flag}, 36'd1);

    // 4: P3 illegal up/left, then legal down
    load(2'd3, 2'b01);
    tap(4'b0001);
    tap(4'b0100);
    check_eq("t4_unchanged", board_flat, 36'h687524310);
    set_btn(4'b0010); step();
    check_eq("t4_active", {35'd0, active}, 36'd1);
    check_eq("t4_blank3", {32'd0, blank_pos}, 36'd3);
    set_btn(4'b0000); step();

    // 5: simultaneous presses ignored; held button moves once
    tap(4'b0101);
    check_eq("t5_blank_same", {32'd0, blank_pos}, 36'd3);
    pulses = 0;
    set_btn(4'b0010);
    for (int i = 0; i < 10; i++) begin step(); if (active) pulses++; end
    set_btn(4'b0000); step();
    check_eq("t5_one_pulse", 36'(pulses), 36'd1);

    // 6: solve, freeze in WINNED, reload, reset mid-game
    load(2'd0, 2'b01);
    tap(4'b1000);
    game_status = 2'b11; steps(2);
    tap(4'b0001); tap(4'b0100);
    check_eq("t6_frozen", board_flat, 36'h087654321);
    check_eq("t6_win_held", {35'd0, win_flag}, 36'd1);
    game_status = 2'b00; board_sel = 2'd2; steps(2);
    check_eq("t6_win_clr", {35'd0, win_flag}, 36'd0);
    check_eq("t6_reload", board_flat, 36'h857640321);
    load(2'd1, 2'b01);
    tap(4'b0100);
    rst = 1'b0; set_btn(4'b0001); step();
    check_eq("t6_rst_p0", board_flat, 36'h807654321);
    rst = 1'b1; steps(2);

    // Randomized play
    for (int n = 0; n < 3000; n++) begin
      rv = $urandom_range(0, 99);
      if (rv < 3) begin
        rv = $urandom_range(0, 99);
        game_status = (rv < 60) ? 2'b01 : (rv < 75) ? 2'b00 : (rv < 90) ? 2'b10 : 2'b11;
      end
      board_sel = 2'($urandom_range(0, 3));
      if ($urandom_range(0, 2) == 0) set_btn(4'($urandom_range(0, 15)));
      else if ($urandom_range(0, 1) == 0) set_btn(4'b0000);
      rst = ($urandom_range(0, 299) != 0);
      step();
    end
    rst = 1'b1;

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
